// File: rtl/id_operand_unit.sv
// Decode-stage operand unit: IF/ID register, stall-safe instruction buffer,
// rs/rt operand forwarding and load-use interlock with a saturating stall counter.
// Latency: ID register and buffer update on the clock edge; operands and stallreq are combinational.
// Backpressure: stall[1] holds or bubbles IF/ID; stall[2] freezes the instruction in a local buffer.
module id_operand_unit #(
    parameter int DATA_W  = 32,
    parameter int NUM_FWD = 3,
    parameter int STALL_W = 6,
    parameter int CNT_W   = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [STALL_W-1:0]        stall,
    input  logic                      if_ce,
    input  logic [DATA_W-1:0]         if_pc,
    input  logic [31:0]               inst_sram_rdata,
    input  logic                      use_rs,
    input  logic                      use_rt,
    output logic [4:0]                rf_raddr1,
    output logic [4:0]                rf_raddr2,
    input  logic [DATA_W-1:0]         rf_rdata1,
    input  logic [DATA_W-1:0]         rf_rdata2,
    input  logic [NUM_FWD-1:0]        fwd_we,
    input  logic [5*NUM_FWD-1:0]      fwd_waddr,
    input  logic [DATA_W*NUM_FWD-1:0] fwd_wdata,
    input  logic                      ex_is_load,
    output logic                      id_valid,
    output logic [DATA_W-1:0]         id_pc,
    output logic [31:0]               id_inst,
    output logic [DATA_W-1:0]         opnd1,
    output logic [DATA_W-1:0]         opnd2,
    output logic                      stallreq,
    output logic [CNT_W-1:0]          luse_cnt
);

    // Only the IF/ID and ID/EX stop bits matter here; the rest of the bus is ignored.
    logic stall_ifid;
    logic stall_idex;
    logic unused_stall;

    assign stall_ifid   = stall[1];
    assign stall_idex   = stall[2];
    assign unused_stall = ^stall;

    logic              id_valid_q;
    logic              id_valid_d;
    logic [DATA_W-1:0] id_pc_q;
    logic [DATA_W-1:0] id_pc_d;
    logic [31:0]       inst_buf_q;
    logic [31:0]       inst_buf_d;
    logic              buf_valid_q;
    logic              buf_valid_d;
    logic [CNT_W-1:0]  luse_cnt_q;
    logic [CNT_W-1:0]  luse_cnt_d;

    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        ex_waddr;
    logic [DATA_W-1:0] opnd1_sel;
    logic [DATA_W-1:0] opnd2_sel;
    logic              luse_hit;

    // IF/ID next state: a bubble when ID moves on but IF is stopped, load when IF advances, else hold.
    always_comb begin
        id_valid_d = id_valid_q;
        id_pc_d    = id_pc_q;
        if (stall_ifid && !stall_idex) begin
            id_valid_d = 1'b0;
            id_pc_d    = '0;
        end else if (!stall_ifid) begin
            id_valid_d = if_ce;
            id_pc_d    = if_pc;
        end
    end

    // Instruction buffer: the SRAM word is only valid the cycle after its PC, so grab it
    // on the first stalled edge and replay it until the ID/EX stall releases.
    always_comb begin
        inst_buf_d  = inst_buf_q;
        buf_valid_d = buf_valid_q;
        if (stall_idex) begin
            if (!buf_valid_q) begin
                inst_buf_d  = inst_sram_rdata;
                buf_valid_d = 1'b1;
            end
        end else begin
            buf_valid_d = 1'b0;
        end
    end

    // Load-use stall counter saturates at all-ones instead of wrapping.
    always_comb begin
        luse_cnt_d = luse_cnt_q;
        if (stallreq && (luse_cnt_q != {CNT_W{1'b1}})) begin
            luse_cnt_d = luse_cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset wins over any stall and drops a buffered instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid_q  <= 1'b0;
            id_pc_q     <= '0;
            inst_buf_q  <= '0;
            buf_valid_q <= 1'b0;
            luse_cnt_q  <= '0;
        end else begin
            id_valid_q  <= id_valid_d;
            id_pc_q     <= id_pc_d;
            inst_buf_q  <= inst_buf_d;
            buf_valid_q <= buf_valid_d;
            luse_cnt_q  <= luse_cnt_d;
        end
    end

    // Decode-stage instruction: buffered copy first, zero for an invalid slot, else live SRAM data.
    always_comb begin
        if (buf_valid_q) begin
            id_inst = inst_buf_q;
        end else if (!id_valid_q) begin
            id_inst = 32'b0;
        end else begin
            id_inst = inst_sram_rdata;
        end
    end

    assign rs        = id_inst[25:21];
    assign rt        = id_inst[20:16];
    assign rf_raddr1 = rs;
    assign rf_raddr2 = rt;

    // Operand forwarding: scan oldest to youngest so the youngest matching source overrides;
    // r0 is hardwired to zero regardless of any source writing it.
    always_comb begin
        opnd1_sel = rf_rdata1;
        opnd2_sel = rf_rdata2;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_we[i] && (fwd_waddr[5*i +: 5] == rs)) begin
                opnd1_sel = fwd_wdata[DATA_W*i +: DATA_W];
            end
            if (fwd_we[i] && (fwd_waddr[5*i +: 5] == rt)) begin
                opnd2_sel = fwd_wdata[DATA_W*i +: DATA_W];
            end
        end
        if (rs == 5'd0) begin
            opnd1_sel = '0;
        end
        if (rt == 5'd0) begin
            opnd2_sel = '0;
        end
    end

    // Load-use interlock: EX holds a load whose nonzero destination feeds a register this instruction reads.
    always_comb begin
        luse_hit = (use_rs && (ex_waddr == rs)) || (use_rt && (ex_waddr == rt));
        stallreq = id_valid_q && ex_is_load && fwd_we[0] && (ex_waddr != 5'd0) && luse_hit;
    end

    assign ex_waddr = fwd_waddr[4:0];
    assign opnd1    = opnd1_sel;
    assign opnd2    = opnd2_sel;
    assign id_valid = id_valid_q;
    assign id_pc    = id_pc_q;
    assign luse_cnt = luse_cnt_q;

endmodule

// File: tb/tb_id_operand_unit.sv
// Bench for id_operand_unit: forwarding priority, r0, load-use interlock, counter saturation,
// stall hold, bubble and reset-in-stall; expected values queued at drive time, popped at sample time.
module tb_id_operand_unit;

    localparam int DW  = 32;
    localparam int NF  = 3;
    localparam int SW  = 6;
    localparam int CW  = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [SW-1:0]  stall;
    logic           if_ce;
    logic [DW-1:0]  if_pc;
    logic [31:0]    inst_sram_rdata;
    logic           use_rs, use_rt;
    logic [4:0]     rf_raddr1, rf_raddr2;
    logic [DW-1:0]  rf_rdata1, rf_rdata2;
    logic [NF-1:0]  fwd_we;
    logic [5*NF-1:0]  fwd_waddr;
    logic [DW*NF-1:0] fwd_wdata;
    logic           ex_is_load;
    logic           id_valid;
    logic [DW-1:0]  id_pc;
    logic [31:0]    id_inst;
    logic [DW-1:0]  opnd1, opnd2;
    logic           stallreq;
    logic [CW-1:0]  luse_cnt;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp;

    id_operand_unit #(.DATA_W(DW), .NUM_FWD(NF), .STALL_W(SW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .stall(stall), .if_ce(if_ce), .if_pc(if_pc),
        .inst_sram_rdata(inst_sram_rdata), .use_rs(use_rs), .use_rt(use_rt),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .ex_is_load(ex_is_load),
        .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst), .opnd1(opnd1), .opnd2(opnd2),
        .stallreq(stallreq), .luse_cnt(luse_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    function automatic logic [31:0] mk_inst(input logic [4:0] rs, input logic [4:0] rt);
        return {6'h09, rs, rt, 16'h0001};
    endfunction

    // Reference operand: first (youngest) matching source wins, r0 always reads zero.
    function automatic logic [31:0] ref_opnd(input logic [4:0] r, input logic [NF-1:0] we,
                                             input logic [5*NF-1:0] wa, input logic [DW*NF-1:0] wd,
                                             input logic [31:0] rf);
        if (r == 5'd0) return 32'd0;
        for (int i = 0; i < NF; i++) begin
            if (we[i] && wa[5*i +: 5] == r) return wd[DW*i +: DW];
        end
        return rf;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Loads a valid instruction slot into ID with the given PC.
    task automatic load_id(input logic [31:0] pc);
        @(negedge clk);
        stall = '0; if_ce = 1'b1; if_pc = pc; ex_is_load = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        inst_sram_rdata = 32'hFFFF_FFFF;
        do_reset();
        exp_q.push_back({32'd0, 32'(id_valid)});
        exp = exp_q.pop_front(); checks++;
        if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid got %0b want 0", id_valid); end
        exp_q.push_back({32'd0, 32'd0});
        exp = exp_q.pop_front(); checks++;
        if (id_pc !== exp[31:0]) begin errors++; $display("FAIL reset_id_pc got %h want %h", id_pc, exp[31:0]); end
        exp_q.push_back({32'd0, 32'd0});
        exp = exp_q.pop_front(); checks++;
        if (id_inst !== exp[31:0]) begin errors++; $display("FAIL reset_id_inst got %h want %h", id_inst, exp[31:0]); end
        checks++;
        if (luse_cnt !== 2'd0) begin errors++; $display("FAIL reset_luse_cnt got %0d want 0", luse_cnt); end
        checks++;
        if (stallreq !== 1'b0) begin errors++; $display("FAIL reset_stallreq got %0b want 0", stallreq); end
    endtask

    task automatic test_forwarding();
        load_id(32'h0000_0040);
        inst_sram_rdata = mk_inst(5'd5, 5'd7);
        rf_rdata1 = 32'h99; rf_rdata2 = 32'h77;
        fwd_waddr = {5'd5, 5'd7, 5'd5};
        fwd_wdata = {32'h33, 32'h22, 32'h11};
        fwd_we    = 3'b111;
        exp_q.push_back({32'h22, 32'h11});
        #1;
        exp = exp_q.pop_front(); checks++;
        if (opnd1 !== exp[31:0]) begin errors++; $display("FAIL fwd_youngest got %h want %h", opnd1, exp[31:0]); end
        checks++;
        if (opnd2 !== exp[63:32]) begin errors++; $display("FAIL fwd_rt_src1 got %h want %h", opnd2, exp[63:32]); end
        checks++;
        if (rf_raddr1 !== 5'd5 || rf_raddr2 !== 5'd7) begin
            errors++; $display("FAIL rf_raddr got %0d/%0d want 5/7", rf_raddr1, rf_raddr2);
        end
        fwd_we = 3'b100;
        exp_q.push_back({32'h77, 32'h33});
        #1;
        exp = exp_q.pop_front(); checks++;
        if (opnd1 !== exp[31:0]) begin errors++; $display("FAIL fwd_oldest got %h want %h", opnd1, exp[31:0]); end
        checks++;
        if (opnd2 !== exp[63:32]) begin errors++; $display("FAIL fwd_rt_rf got %h want %h", opnd2, exp[63:32]); end
        fwd_we = 3'b000;
        exp_q.push_back({32'h77, 32'h99});
        #1;
        exp = exp_q.pop_front(); checks++;
        if (opnd1 !== exp[31:0]) begin errors++; $display("FAIL fwd_none got %h want %h", opnd1, exp[31:0]); end
        // Random patterns over a small register range so collisions are frequent.
        for (int n = 0; n < 24; n++) begin
            logic [4:0] rs, rt;
            rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3));
            inst_sram_rdata = mk_inst(rs, rt);
            rf_rdata1 = $urandom; rf_rdata2 = $urandom;
            fwd_we = 3'($urandom_range(0, 7));
            for (int i = 0; i < NF; i++) begin
                fwd_waddr[5*i +: 5] = 5'($urandom_range(0, 3));
                fwd_wdata[DW*i +: DW] = $urandom;
            end
            exp_q.push_back({ref_opnd(rt, fwd_we, fwd_waddr, fwd_wdata, rf_rdata2),
                             ref_opnd(rs, fwd_we, fwd_waddr, fwd_wdata, rf_rdata1)});
            #1;
            exp = exp_q.pop_front(); checks++;
            if (opnd1 !== exp[31:0] || opnd2 !== exp[63:32]) begin
                errors++; $display("FAIL fwd_random[%0d] got %h/%h want %h/%h", n, opnd1, opnd2, exp[31:0], exp[63:32]);
            end
        end
        fwd_we = '0;
    endtask

    task automatic test_zero_reg();
        load_id(32'h0000_0044);
        inst_sram_rdata = mk_inst(5'd0, 5'd0);
        fwd_waddr = {5'd0, 5'd0, 5'd0};
        fwd_wdata = {32'h1, 32'h2, 32'hFFFF_FFFF};
        fwd_we = 3'b001; ex_is_load = 1'b1; use_rs = 1'b1; use_rt = 1'b1;
        rf_rdata1 = 32'h55;
        exp_q.push_back({32'd0, 32'd0});
        #1;
        exp = exp_q.pop_front(); checks++;
        if (opnd1 !== exp[31:0]) begin errors++; $display("FAIL zero_reg_opnd1 got %h want %h", opnd1, exp[31:0]); end
        checks++;
        if (stallreq !== 1'b0) begin errors++; $display("FAIL zero_reg_stallreq got %0b want 0", stallreq); end
        ex_is_load = 1'b0; fwd_we = '0;
    endtask

    task automatic test_load_use_and_saturation();
        do_reset();
        load_id(32'h0000_0048);
        inst_sram_rdata = mk_inst(5'd3, 5'd8);
        fwd_waddr = {5'd0, 5'd0, 5'd8};
        fwd_we = 3'b001; ex_is_load = 1'b1; use_rs = 1'b0; use_rt = 1'b1;
        #1; checks++;
        if (stallreq !== 1'b1) begin errors++; $display("FAIL luse_stallreq got %0b want 1", stallreq); end
        repeat (2) @(posedge clk);
        @(negedge clk); checks++;
        if (luse_cnt !== 2'd2) begin errors++; $display("FAIL luse_cnt_two got %0d want 2", luse_cnt); end
        use_rt = 1'b0;
        #1; checks++;
        if (stallreq !== 1'b0) begin errors++; $display("FAIL luse_no_use got %0b want 0", stallreq); end
        @(posedge clk); @(negedge clk); checks++;
        if (luse_cnt !== 2'd2) begin errors++; $display("FAIL luse_cnt_hold got %0d want 2", luse_cnt); end
        use_rt = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); checks++;
        if (luse_cnt !== 2'd3) begin errors++; $display("FAIL luse_cnt_sat got %0d want 3", luse_cnt); end
        // Buffer an instruction under stall, then reset in the middle of the stall.
        ex_is_load = 1'b0; fwd_we = '0;
        inst_sram_rdata = 32'h1234_5678; stall = 6'b000110;
        @(posedge clk); @(negedge clk);
        inst_sram_rdata = 32'hCAFE_0000;
        #1; checks++;
        if (id_inst !== 32'h1234_5678) begin errors++; $display("FAIL rst_pre_buf got %h want 12345678", id_inst); end
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        #1; checks++;
        if (luse_cnt !== 2'd0) begin errors++; $display("FAIL rst_luse_cnt got %0d want 0", luse_cnt); end
        checks++;
        if (id_inst !== 32'd0 || id_valid !== 1'b0 || id_pc !== 32'd0) begin
            errors++; $display("FAIL rst_mid_stall got inst=%h v=%0b pc=%h want 0/0/0", id_inst, id_valid, id_pc);
        end
        stall = '0;
    endtask

    task automatic test_stall_hold();
        do_reset();
        load_id(32'h0000_0100);
        inst_sram_rdata = 32'h2408_0001;
        stall = 6'b000110;
        @(posedge clk);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            inst_sram_rdata = 32'hDEAD_0000 + 32'(c);
            if_pc = 32'h0000_0200 + 32'(c);
            exp_q.push_back({32'h0000_0100, 32'h2408_0001});
            #1;
            exp = exp_q.pop_front(); checks++;
            if (id_inst !== exp[31:0] || id_pc !== exp[63:32] || id_valid !== 1'b1) begin
                errors++; $display("FAIL stall_hold[%0d] got inst=%h pc=%h v=%0b want %h/%h/1",
                                   c, id_inst, id_pc, id_valid, exp[31:0], exp[63:32]);
            end
            @(posedge clk);
        end
        @(negedge clk);
        stall = '0; if_pc = 32'h0000_0104;
        @(posedge clk); @(negedge clk);
        inst_sram_rdata = 32'h3C01_BEEF;
        exp_q.push_back({32'h0000_0104, 32'h3C01_BEEF});
        #1;
        exp = exp_q.pop_front(); checks++;
        if (id_inst !== exp[31:0] || id_pc !== exp[63:32]) begin
            errors++; $display("FAIL stall_release got inst=%h pc=%h want %h/%h", id_inst, id_pc, exp[31:0], exp[63:32]);
        end
    endtask

    task automatic test_bubble();
        load_id(32'h0000_0300);
        inst_sram_rdata = 32'h0123_4567;
        #1; checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h300) begin
            errors++; $display("FAIL bubble_pre got v=%0b pc=%h want 1/300", id_valid, id_pc);
        end
        stall = 6'b000010;
        @(posedge clk); @(negedge clk);
        exp_q.push_back({32'd0, 32'd0});
        #1;
        exp = exp_q.pop_front(); checks++;
        if (id_valid !== 1'b0 || id_pc !== exp[63:32] || id_inst !== exp[31:0]) begin
            errors++; $display("FAIL bubble got v=%0b pc=%h inst=%h want 0/0/0", id_valid, id_pc, id_inst);
        end
        stall = '0;
    endtask

    initial begin
        rst = 1'b0; stall = '0; if_ce = 1'b0; if_pc = '0; inst_sram_rdata = '0;
        use_rs = 1'b0; use_rt = 1'b0; rf_rdata1 = '0; rf_rdata2 = '0;
        fwd_we = '0; fwd_waddr = '0; fwd_wdata = '0; ex_is_load = 1'b0;
        test_reset();
        test_forwarding();
        test_zero_reg();
        test_load_use_and_saturation();
        test_stall_hold();
        test_bubble();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
